// File: rtl/bob_except_pkg.sv
// bob_except_pkg: shared constants, FSM state type and pointer helper for the
// retire-bundle exception store sequencer.
//   EXC_DEPTH  - bundle slots in the store
//   EXC_LANES  - lane records per bundle
//   EXC_PTR_W  - slot pointer width
//   EXC_DATA_W - record width (bit 0 = exception present)
package bob_except_pkg;

  localparam int EXC_DEPTH  = 48;
  localparam int EXC_LANES  = 10;
  localparam int EXC_PTR_W  = 6;
  localparam int EXC_DATA_W = 8;
  localparam int EXC_CNT_W  = 7;
  localparam int EXC_LANE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_PRESENT = 2'd2
  } exc_state_e;

  // Circular increment: 'last' is the highest valid slot index.
  function automatic logic [EXC_PTR_W-1:0] ptr_inc(input logic [EXC_PTR_W-1:0] p,
                                                   input logic [EXC_PTR_W-1:0] last);
    return (p == last) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/bob_except_ctl_if.sv
// bob_except_ctl_if: bundles the allocate, completion, store-access, retire and
// flush signals of the exception sequencer.
//   slave  - sequencer side (drives grants, store addresses, retire outputs)
//   master - surrounding pipeline / store side
interface bob_except_ctl_if
  import bob_except_pkg::*;
#(
  parameter int LANES      = EXC_LANES,
  parameter int DATA_WIDTH = EXC_DATA_W
) ();

  logic                        alloc_valid;
  logic                        alloc_ready;
  logic [EXC_PTR_W-1:0]        alloc_id;
  logic [EXC_PTR_W-1:0]        writeInit_addr;
  logic                        writeInit_wen;
  logic                        done_wen;
  logic [EXC_PTR_W-1:0]        done_id;
  logic                        read_step;
  logic [EXC_PTR_W-1:0]        read_addr;
  logic [LANES*DATA_WIDTH-1:0] rd_data;
  logic                        retire_valid;
  logic                        retire_ready;
  logic [EXC_PTR_W-1:0]        retire_id;
  logic                        exc_any;
  logic [EXC_LANE_W-1:0]       exc_lane;
  logic                        flush;
  logic [EXC_CNT_W-1:0]        count;

  modport slave (
    input  alloc_valid, done_wen, done_id, rd_data, retire_ready, flush,
    output alloc_ready, alloc_id, writeInit_addr, writeInit_wen, read_step,
           read_addr, retire_valid, retire_id, exc_any, exc_lane, count
  );

  modport master (
    output alloc_valid, done_wen, done_id, rd_data, retire_ready, flush,
    input  alloc_ready, alloc_id, writeInit_addr, writeInit_wen, read_step,
           read_addr, retire_valid, retire_id, exc_any, exc_lane, count
  );

endinterface

// File: rtl/bob_except_prio.sv
// bob_except_prio: lowest-index priority encoder over the per-lane exception bits.
//   req  - one request bit per lane
//   any  - at least one request present
//   lane - index of the lowest set request, 0 when none
module bob_except_prio
  import bob_except_pkg::*;
#(
  parameter int N = EXC_LANES
) (
  input  logic [N-1:0]          req,
  output logic                  any,
  output logic [EXC_LANE_W-1:0] lane
);

  // Scan from the top down so the lowest set bit is the last to overwrite.
  always_comb begin
    any  = |req;
    lane = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) lane = EXC_LANE_W'(i);
    end
  end

endmodule

// File: rtl/bob_except_ctl.sv
// bob_except_ctl: sequencer for the banked retire-bundle exception store.
// Allocates bundle slots in circular order (issuing the store init write),
// tracks per-slot completion, and in program order reads the oldest completed
// bundle and presents it to retire with its first-exception lane.
//   clk, rst - clock and asynchronous active-low reset
//   bus      - allocate / done / store read / retire / flush signals (slave side)
module bob_except_ctl
  import bob_except_pkg::*;
#(
  parameter int DEPTH      = EXC_DEPTH,
  parameter int LANES      = EXC_LANES,
  parameter int DATA_WIDTH = EXC_DATA_W
) (
  input logic             clk,
  input logic             rst,
  bob_except_ctl_if.slave bus
);

  localparam logic [EXC_PTR_W-1:0] LAST_SLOT = EXC_PTR_W'(DEPTH - 1);

  exc_state_e            state_reg, state_next;
  logic [EXC_PTR_W-1:0]  head_reg, head_next;
  logic [EXC_PTR_W-1:0]  tail_reg, tail_next;
  logic [EXC_CNT_W-1:0]  count_reg, count_next;
  logic [DEPTH-1:0]      done_reg, done_next;
  logic                  exc_any_reg;
  logic [EXC_LANE_W-1:0] exc_lane_reg;
  logic [EXC_PTR_W-1:0]  retire_id_reg;

  logic                  alloc_ready;
  logic                  alloc_fire;
  logic                  retire_fire;
  logic                  start_read;
  logic [LANES-1:0]      exc_bits;
  logic                  prio_any;
  logic [EXC_LANE_W-1:0] prio_lane;

  // Flush takes priority over every handshake in its cycle.
  assign alloc_ready = (count_reg < EXC_CNT_W'(DEPTH)) && !bus.flush;
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign retire_fire = (state_reg == ST_PRESENT) && bus.retire_ready && !bus.flush;
  // Empty check guards against stale done bits at the head slot.
  assign start_read  = (state_reg == ST_IDLE) && (count_reg != '0) &&
                       done_reg[head_reg] && !bus.flush;

  // Bit 0 of every lane record is its exception flag.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign exc_bits[gi] = bus.rd_data[gi*DATA_WIDTH];
    end
  endgenerate

  bob_except_prio #(.N(LANES)) u_prio (
    .req  (exc_bits),
    .any  (prio_any),
    .lane (prio_lane)
  );

  // Pointer, occupancy and completion bookkeeping.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    done_next  = done_reg;
    if (bus.done_wen) done_next[bus.done_id] = 1'b1;
    // Clears are applied after the set so a same-slot clear wins.
    if (alloc_fire) begin
      done_next[tail_reg] = 1'b0;
      tail_next           = ptr_inc(tail_reg, LAST_SLOT);
    end
    if (retire_fire) begin
      done_next[head_reg] = 1'b0;
      head_next           = ptr_inc(head_reg, LAST_SLOT);
    end
    case ({alloc_fire, retire_fire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (bus.flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
      done_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      done_reg  <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  // Capture the scan result while the store data is valid; it stays held
  // through PRESENT regardless of what rd_data does afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_any_reg   <= 1'b0;
      exc_lane_reg  <= '0;
      retire_id_reg <= '0;
    end else if (state_reg == ST_READ) begin
      exc_any_reg   <= prio_any;
      exc_lane_reg  <= prio_lane;
      retire_id_reg <= head_reg;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start_read) state_next = ST_READ;
      ST_READ:    state_next = ST_PRESENT;
      ST_PRESENT: if (bus.retire_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (bus.flush) state_next = ST_IDLE;
  end

  // FSM: outputs
  always_comb begin
    bus.read_step    = start_read;
    bus.retire_valid = (state_reg == ST_PRESENT);
  end

  assign bus.alloc_ready    = alloc_ready;
  assign bus.alloc_id       = tail_reg;
  assign bus.writeInit_addr = tail_reg;
  assign bus.writeInit_wen  = alloc_fire;
  assign bus.read_addr      = head_reg;
  assign bus.retire_id      = retire_id_reg;
  assign bus.exc_any        = exc_any_reg;
  assign bus.exc_lane       = exc_lane_reg;
  assign bus.count          = count_reg;

endmodule

// File: doc/bob_except_ctl.md
# bob_except_ctl

Sequencer for the banked retire-bundle exception store: 48 bundle slots × 10 lane records.
- Allocates one slot per incoming bundle in circular order and initialises its records through the store's init write port.
- Tracks per-slot completion.
- In program order, reads the oldest completed bundle's 10 records and presents them to retire with a priority-encoded first-exception lane.
- Sits between rename/allocate and the retire stage, next to the exception store.

## Interface
Parameters:
- DEPTH, 48, bundle slots; the pointer width is 6.
- LANES, 10, records per bundle.
- DATA_WIDTH, `except_width, record width; bit 0 of each record = exception present.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- alloc_valid  input  1  new bundle requests a slot
- alloc_ready  output  1  slot available and no flush
- alloc_id  output  6  slot granted (current tail)
- writeInit_addr  output  6  init write address to store (= tail)
- writeInit_wen  output  1  init write enable
- done_wen  input  1  bundle completion strobe
- done_id  input  6  slot completed
- read_step  output  1  store read-address capture strobe
- read_addr  output  6  store read address (= head)
- rd_data  input  LANES*DATA_WIDTH  store read data; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
- retire_valid  output  1  head bundle presented
- retire_ready  input  1  retire stage accepts
- retire_id  output  6  presented slot
- exc_any  output  1  any lane of presented bundle has an exception
- exc_lane  output  4  lowest lane with an exception; 0 when exc_any=0
- flush  input  1  synchronous pipeline flush
- count  output  7  occupied slots, 0..48

## Operation
- State: head, tail (0..47), count, done[47:0], FSM {IDLE, READ, PRESENT}, captured exc_any/exc_lane/retire_id registers.
- Allocate: alloc_ready = (count<48) && !flush.
  - On alloc_valid && alloc_ready: writeInit_wen=1 and writeInit_addr=tail, both combinational the same cycle.
  - The same cycle, tail increments, wrapping 47→0, and done[tail] clears.
- Complete: done_wen sets done[done_id]. If alloc clears the same slot in the same cycle, the clear wins.
- FSM:
  - IDLE: if count>0 && done[head], assert read_step with read_addr=head, then go to READ.
  - READ: rd_data is valid. Scan bit 0 of each lane, capture exc_any/exc_lane/retire_id=head, then go to PRESENT.
  - PRESENT: retire_valid=1, outputs held stable. On retire_ready: head increments (wrap 47→0), done[head] clears, go to IDLE.
- count update: +1 on alloc only, −1 on retire handshake only, unchanged when both occur in the same cycle.
- flush: next edge clears head, tail, count and done[], and forces the FSM to IDLE. flush overrides alloc, done and retire handshakes in the same cycle.
- read_step is asserted only in IDLE on the transition; read_addr is don't-care otherwise and is driven to head.

## Timing
- Reset (rst=0, asynchronous) values:
  - head=tail=0, count=0, done=0, FSM=IDLE.
  - alloc_ready=1, alloc_id=0, writeInit_wen=0, writeInit_addr=0.
  - read_step=0, read_addr=0.
  - retire_valid=0, retire_id=0, exc_any=0, exc_lane=0.
- Latency:
  - done_wen at edge N on the head slot → read_step in cycle N+1 → retire_valid from cycle N+3.
  - Best-case throughput is one bundle per 3 cycles.
- Full: count=48 gives alloc_ready=0. A retire handshake in that cycle does not reopen allocation until the next cycle.
- Empty: count=0 keeps the FSM in IDLE even if stale done bits exist.
- Reset mid-PRESENT drops retire_valid immediately (asynchronous).

## Structure
- Package bob_except_pkg holds:
  - EXC_DEPTH=48, EXC_LANES=10, EXC_PTR_W=6.
  - FSM enum typedef.
  - Pointer-increment-with-wrap function.
- Sub-module bob_except_prio: 10-input lowest-index priority encoder with outputs any and lane[3:0].

## Test plan
- Reset, then 48 allocs back-to-back: alloc_id 0..47, writeInit_wen each cycle; after the 48th, count=48 and alloc_ready=0.
- Alloc 1, done_wen id 0 at edge N, rd_data with lanes 3 and 7 bit0=1: retire_valid at N+3, retire_id=0, exc_any=1, exc_lane=3.
- Done completes out of order (slot 2, then 1, then 0): retire order is 0,1,2; no retire_valid before done[0] is set.
- Head=47 with retire_ready held low 5 cycles: outputs stable; after handshake, head wraps to 0 and count decrements by 1.
- Full, with simultaneous alloc and retire: count stays 48 that cycle and alloc_ready rises the next cycle.
- flush during PRESENT with alloc_valid=1: next cycle count=0, retire_valid=0, no writeInit_wen, and alloc_id=0.
